cp_strip_deser: RTL

Receive-side companion to the cyclic-prefix insertion / serializer stage: consumes its MSB-first serial bitstream (9 × 32-bit words per OFDM symbol: CP word followed by samples 0..7) and rebuilds the 8 parallel complex samples. The CP word is stripped and checked against sample 7, the word it must duplicate. The block sits at the end of the modulator chain, as the loopback/self-check path on the FPGA and as the reference deserializer in system benches.

---
 rtl/ofdm_pkg.sv | 37 +++
 rtl/sipo_word.sv | 50 +++++
 rtl/cp_strip_deser.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/ofdm_pkg.sv
// ---------------------------------------------------------------------------
// ofdm_pkg
// Constants and types shared by the OFDM cyclic-prefix serializer and its
// receive-side companion (cp_strip_deser).
//   WORD_W      : bits per serial word (one complex sample)
//   N_SC        : samples per OFDM symbol
//   FRAME_WORDS : words per frame (CP word + N_SC samples)
//   SAMPLE_W    : bits per real / imaginary component
//   cplx_t      : packed complex sample, re in the upper half of the word
//   rx_state_t  : receive-side control state
// ---------------------------------------------------------------------------
package ofdm_pkg;

   localparam int WORD_W      = 32;
   localparam int N_SC        = 8;
   localparam int FRAME_WORDS = N_SC + 1;
   localparam int SAMPLE_W    = 16;

   localparam int BIT_CNT_W  = $clog2(WORD_W);
   localparam int WORD_CNT_W = $clog2(FRAME_WORDS);

   typedef struct packed {
      logic [SAMPLE_W-1:0] re;
      logic [SAMPLE_W-1:0] im;
   } cplx_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RECV = 1'b1
   } rx_state_t;

   // Reinterpret a serial word as a complex sample: bits [31:16] are re.
   function automatic cplx_t word_to_cplx(input logic [WORD_W-1:0] w);
      return cplx_t'(w);
   endfunction

endpackage

// File: rtl/sipo_word.sv
// ---------------------------------------------------------------------------
// sipo_word
// Serial-in / parallel-out word assembler. Bits arrive MSB first and shift in
// at the LSB. The bit counter wraps 31 -> 0 on its own, so the word boundary
// needs no extra logic.
// Ports:
//   clk, rst   : clock, asynchronous active-low reset
//   clear      : synchronous clear of the counter and shift state
//   sample     : take bitIn on this edge
//   bitIn      : serial data bit
//   word       : the word that completes if this edge samples bit 31
//   bitCnt     : index of the next bit within the word (0..31)
//   wordDone   : strobe, high when this edge samples the last bit of a word
// ---------------------------------------------------------------------------
module sipo_word
   import ofdm_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clear,
   input  logic                 sample,
   input  logic                 bitIn,
   output logic [WORD_W-1:0]    word,
   output logic [BIT_CNT_W-1:0] bitCnt,
   output logic                 wordDone
);

   // Only 31 bits need storage: the 32nd bit of a word is the live input on
   // the edge that completes it.
   logic [WORD_W-2:0] shift;

   // NOTE: sequential state uses non-blocking assignments so every flop sees
   // the pre-edge values of the others, independent of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shift  <= '0;
         bitCnt <= '0;
      end else if (clear) begin
         shift  <= '0;
         bitCnt <= '0;
      end else if (sample) begin
         shift  <= {shift[WORD_W-3:0], bitIn};
         bitCnt <= bitCnt + 1'b1;
      end
   end

   assign word     = {shift, bitIn};
   assign wordDone = sample && (bitCnt == BIT_CNT_W'(WORD_W - 1));

endmodule

// File: rtl/cp_strip_deser.sv
// ---------------------------------------------------------------------------
// cp_strip_deser
// Receive-side deserializer for the cyclic-prefix serializer. A frame is
// N_SC+1 serial 32-bit words, MSB first: the CP word, then samples 0..N_SC-1.
// The CP word is kept and compared with the last sample, which it duplicates.
// Samples 0..N_SC-2 collect in an internal holding bank, so the visible
// outputs change only when a whole frame has arrived.
// Ports:
//   clk, rst              : clock, asynchronous active-low reset
//   start                 : enable; low holds the block idle and aborts a frame
//   serialIn, inValid     : serial data and its qualifier
//   out0R..out7R          : real parts (bits [31:16]) of samples 0..7
//   out0I..out7I          : imaginary parts (bits [15:0]) of samples 0..7
//   outValid              : one-cycle pulse when a new symbol is on the outputs
//   cpErr                 : CP word differed from the last sample (with outValid)
//   busy                  : a frame is partially received
// ---------------------------------------------------------------------------
module cp_strip_deser #(
   parameter int SAMPLE_W = 16,
   parameter int N_SC     = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                serialIn,
   input  logic                inValid,
   output logic [SAMPLE_W-1:0] out0R,
   output logic [SAMPLE_W-1:0] out1R,
   output logic [SAMPLE_W-1:0] out2R,
   output logic [SAMPLE_W-1:0] out3R,
   output logic [SAMPLE_W-1:0] out4R,
   output logic [SAMPLE_W-1:0] out5R,
   output logic [SAMPLE_W-1:0] out6R,
   output logic [SAMPLE_W-1:0] out7R,
   output logic [SAMPLE_W-1:0] out0I,
   output logic [SAMPLE_W-1:0] out1I,
   output logic [SAMPLE_W-1:0] out2I,
   output logic [SAMPLE_W-1:0] out3I,
   output logic [SAMPLE_W-1:0] out4I,
   output logic [SAMPLE_W-1:0] out5I,
   output logic [SAMPLE_W-1:0] out6I,
   output logic [SAMPLE_W-1:0] out7I,
   output logic                outValid,
   output logic                cpErr,
   output logic                busy
);

   import ofdm_pkg::*;

   // ------------------------------------------------------------------------
   // Control FSM: IDLE while start is low, RECV while it is high. Sampling is
   // gated by start directly, so a bit presented on the same edge that start
   // rises is taken as bit 0. Leaving RECV aborts any partial frame.
   // ------------------------------------------------------------------------
   rx_state_t state, state_nxt;
   logic      sample;
   logic      clear;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = start ? ST_RECV : ST_IDLE;
   end

   always_comb begin
      // NOTE: every combinational output gets a default before the case so no
      // path through the block leaves a value unassigned and infers a latch.
      sample = 1'b0;
      clear  = 1'b0;
      case (state)
         ST_IDLE: begin
            sample = start && inValid;
         end
         ST_RECV: begin
            sample = start && inValid;
            clear  = !start;
         end
         default: begin
            clear  = 1'b1;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Word assembly
   // ------------------------------------------------------------------------
   logic [WORD_W-1:0]    word;
   logic [BIT_CNT_W-1:0] bitCnt;
   logic                 wordDone;

   sipo_word u_sipo (
      .clk      (clk),
      .rst      (rst),
      .clear    (clear),
      .sample   (sample),
      .bitIn    (serialIn),
      .word     (word),
      .bitCnt   (bitCnt),
      .wordDone (wordDone)
   );

   // ------------------------------------------------------------------------
   // Frame assembly: word counter, CP register, holding bank, output bank
   // ------------------------------------------------------------------------
   logic [WORD_CNT_W-1:0] wordCnt;
   logic [WORD_W-1:0]     cpReg;
   cplx_t                 bank  [N_SC-1];
   cplx_t                 out_q [N_SC];
   logic                  out_valid_q;
   logic                  cp_err_q;
   logic                  frame_done;

   assign frame_done = wordDone && (wordCnt == WORD_CNT_W'(N_SC));

   // NOTE: the holding bank and output bank are reset like any other register;
   // the outputs must read zero out of reset and they are only a few flops.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wordCnt     <= '0;
         cpReg       <= '0;
         out_valid_q <= 1'b0;
         cp_err_q    <= 1'b0;
         for (int k = 0; k < N_SC - 1; k++) bank[k]  <= '0;
         for (int k = 0; k < N_SC; k++)     out_q[k] <= '0;
      end else begin
         out_valid_q <= 1'b0;
         if (clear) begin
            wordCnt <= '0;
         end else if (wordDone) begin
            if (wordCnt == '0) begin
               cpReg <= word;
            end
            for (int k = 0; k < N_SC - 1; k++) begin
               if (wordCnt == WORD_CNT_W'(k + 1)) bank[k] <= word_to_cplx(word);
            end
            if (frame_done) begin
               // The completed word is the last sample; it goes straight to
               // the outputs alongside the bank.
               for (int k = 0; k < N_SC - 1; k++) out_q[k] <= bank[k];
               out_q[N_SC-1] <= word_to_cplx(word);
               cp_err_q      <= (cpReg != word);
               out_valid_q   <= 1'b1;
               wordCnt       <= '0;
            end else begin
               wordCnt <= wordCnt + 1'b1;
            end
         end
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign out0R = out_q[0].re;
   assign out1R = out_q[1].re;
   assign out2R = out_q[2].re;
   assign out3R = out_q[3].re;
   assign out4R = out_q[4].re;
   assign out5R = out_q[5].re;
   assign out6R = out_q[6].re;
   assign out7R = out_q[7].re;
   assign out0I = out_q[0].im;
   assign out1I = out_q[1].im;
   assign out2I = out_q[2].im;
   assign out3I = out_q[3].im;
   assign out4I = out_q[4].im;
   assign out5I = out_q[5].im;
   assign out6I = out_q[6].im;
   assign out7I = out_q[7].im;

   assign outValid = out_valid_q;
   assign cpErr    = cp_err_q;
   assign busy     = (bitCnt != '0) || (wordCnt != '0);

endmodule
